tf_update_engine: RTL and testbench

//  Parametrised twiddle-factor store and update engine for the NWC/NTT datapath. Holds BANKS twiddle bases
//  per iteration depth and a table of per-stage multiplier constants. On request it emits one depth's bases and

---
 rtl/tf_update_engine_pkg.sv | 34 +++
 rtl/tf_update_engine_if.sv | 37 +++
 rtl/tf_update_engine_barrett.sv | 34 +++
 rtl/tf_update_engine.sv | 141 ++++++++++++++
 tb/tb_tf_update_engine.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tf_update_engine_pkg.sv
// Shared defaults, word/state types and the constant-table index helper for
// the twiddle-factor update engine.
package tf_update_engine_pkg;

    localparam int unsigned TF_DW      = 32;
    localparam int unsigned TF_BANKS   = 15;
    localparam int unsigned TF_DEPTH   = 3;
    localparam int unsigned TF_LOG_N   = 12;
    localparam int unsigned TF_RADIX_K = 4;
    localparam int unsigned TF_MUL_LAT = 3;

    typedef logic [TF_DW-1:0] tf_word_t;
    typedef logic [1:0]       tf_state_t;

    localparam tf_state_t ST_IDLE = 2'd0;
    localparam tf_state_t ST_READ = 2'd1;
    localparam tf_state_t ST_WAIT = 2'd2;
    localparam tf_state_t ST_WB   = 2'd3;

    // idx = log_n - radix_k*d - floor(log2 m); may be negative
    function automatic int tf_const_idx(input int d, input int m,
                                        input int log_n, input int radix_k);
        int unsigned v;
        int          lg;
        v  = unsigned'(m);
        lg = 0;
        while (v > 1) begin
            v  = v >> 1;
            lg = lg + 1;
        end
        return log_n - radix_k * d - lg;
    endfunction

endpackage

// File: rtl/tf_update_engine_if.sv
// Load/request/response bundle between a controller and tf_update_engine.
interface tf_update_engine_if #(
    parameter int unsigned DW      = 32,
    parameter int unsigned BANKS   = 15,
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned CONST_N = 13
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0]         modulus;
    logic                  base_wr_en;
    logic [AW-1:0]         base_wr_depth;
    logic [BANKS*DW-1:0]   base_wr_data;
    logic                  const_wr_en;
    logic [CONST_N*DW-1:0] const_wr_data;
    logic                  tf_req;
    logic [AW-1:0]         tf_depth;
    logic                  tf_update;
    logic                  tf_ready;
    logic                  tf_valid;
    logic [BANKS*DW-1:0]   tf_out;
    logic                  tf_done;
    logic                  tf_err;

    modport slave (
        input  modulus, base_wr_en, base_wr_depth, base_wr_data,
               const_wr_en, const_wr_data, tf_req, tf_depth, tf_update,
        output tf_ready, tf_valid, tf_out, tf_done, tf_err
    );

    modport master (
        output modulus, base_wr_en, base_wr_depth, base_wr_data,
               const_wr_en, const_wr_data, tf_req, tf_depth, tf_update,
        input  tf_ready, tf_valid, tf_out, tf_done, tf_err
    );

endinterface

// File: rtl/tf_update_engine_barrett.sv
// Pipelined modular multiplier: r = a*b mod q, LAT register stages from
// operands to result. The modulus is a run-time input, so reduction is generic.
module barrett_reduction #(
    parameter int unsigned DW  = 32,
    parameter int unsigned LAT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [DW-1:0] q_i,
    output logic [DW-1:0] r_o
);
    logic [2*DW-1:0] full;
    logic [DW-1:0]   rem;
    logic [DW-1:0]   pipe_q [LAT];

    always_comb begin
        full = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
        rem  = DW'(full % {{DW{1'b0}}, q_i});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= rem;
            for (int unsigned i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign r_o = pipe_q[LAT-1];

endmodule

// File: rtl/tf_update_engine.sv
// Twiddle-factor store: emits one depth's BANKS bases on request and can write
// back base*const mod q after the multiplier latency.
module tf_update_engine
    import tf_update_engine_pkg::*;
#(
    parameter int unsigned DW      = TF_DW,
    parameter int unsigned BANKS   = TF_BANKS,
    parameter int unsigned DEPTH   = TF_DEPTH,
    parameter int unsigned LOG_N   = TF_LOG_N,
    parameter int unsigned RADIX_K = TF_RADIX_K,
    parameter int unsigned MUL_LAT = TF_MUL_LAT,
    parameter int unsigned CONST_N = LOG_N + 1
) (
    input logic              clk,
    input logic              rst,
    tf_update_engine_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(MUL_LAT + 1);
    localparam int unsigned IW = (CONST_N > 1) ? $clog2(CONST_N) : 1;

    tf_state_t           state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       depth_q;
    logic                upd_q;
    logic [DW-1:0]       base_q  [DEPTH][BANKS];
    logic [DW-1:0]       const_q [CONST_N];
    logic [BANKS*DW-1:0] out_q;
    logic                valid_q, done_q, err_q;
    logic [DW-1:0]       opa_q [BANKS];
    logic [DW-1:0]       opb_q [BANKS];
    logic [DW-1:0]       opb_d [BANKS];
    logic [DW-1:0]       prod  [BANKS];
    logic                accept, in_range;
    int                  idx;

    assign accept   = (state_q == ST_IDLE) && bus.tf_req;
    assign in_range = 32'(bus.tf_depth) < DEPTH;

    // Out-of-table constant indices multiply by 1, leaving the lane unchanged.
    always_comb begin
        idx = 0;
        for (int unsigned m = 0; m < BANKS; m++) begin
            opb_d[m] = DW'(1);
            for (int unsigned d = 0; d < DEPTH; d++) begin
                if (32'(bus.tf_depth) == d) begin
                    idx = tf_const_idx(int'(d), int'(m + 1), int'(LOG_N), int'(RADIX_K));
                    if (idx >= 0 && idx < int'(CONST_N)) opb_d[m] = const_q[IW'(idx)];
                end
            end
        end
    end

    // WAIT exits with the counter at 1 so the writeback edge lands at t+MUL_LAT+1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (accept && in_range) state_d = ST_READ;
            ST_READ: begin
                cnt_d   = CW'(MUL_LAT - 1);
                state_d = upd_q ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                if (cnt_q <= CW'(1)) state_d = ST_WB;
                else                 cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            depth_q <= '0;
            upd_q   <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int unsigned d = 0; d < DEPTH; d++)
                for (int unsigned m = 0; m < BANKS; m++) base_q[d][m] <= '0;
            for (int unsigned i = 0; i < CONST_N; i++) const_q[i] <= '0;
            for (int unsigned m = 0; m < BANKS; m++) begin
                opa_q[m] <= '0;
                opb_q[m] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (bus.base_wr_en && 32'(bus.base_wr_depth) < DEPTH)
                    for (int unsigned m = 0; m < BANKS; m++)
                        base_q[bus.base_wr_depth][m] <= bus.base_wr_data[m*DW +: DW];
                if (bus.const_wr_en)
                    for (int unsigned i = 0; i < CONST_N; i++)
                        const_q[i] <= bus.const_wr_data[i*DW +: DW];
            end
            if (accept) begin
                if (in_range) begin
                    valid_q <= 1'b1;
                    depth_q <= bus.tf_depth;
                    upd_q   <= bus.tf_update;
                    for (int unsigned m = 0; m < BANKS; m++) begin
                        out_q[m*DW +: DW] <= base_q[bus.tf_depth][m];
                        opa_q[m]          <= base_q[bus.tf_depth][m];
                        opb_q[m]          <= opb_d[m];
                    end
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (state_q == ST_WB) begin
                done_q <= 1'b1;
                for (int unsigned m = 0; m < BANKS; m++) base_q[depth_q][m] <= prod[m];
            end
        end
    end

    for (genvar g = 0; g < BANKS; g++) begin : g_lane
        barrett_reduction #(.DW(DW), .LAT(MUL_LAT)) u_mul (
            .clk (clk),
            .rst (rst),
            .a_i (opa_q[g]),
            .b_i (opb_q[g]),
            .q_i (bus.modulus),
            .r_o (prod[g])
        );
    end

    assign bus.tf_ready = (state_q == ST_IDLE);
    assign bus.tf_valid = valid_q;
    assign bus.tf_out   = out_q;
    assign bus.tf_done  = done_q;
    assign bus.tf_err   = err_q;

endmodule

// File: tb/tb_tf_update_engine.sv
// Directed bench for tf_update_engine: read/update timing, constant indexing,
// error/ignore paths, reset abort, plus a RADIX_K=6 instance for idx<0 lanes.
module tb_tf_update_engine;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tf_update_engine_if #(.DW(32), .BANKS(15), .DEPTH(3), .CONST_N(13)) tif ();
    tf_update_engine_if #(.DW(32), .BANKS(2),  .DEPTH(3), .CONST_N(13)) tif2 ();

    tf_update_engine #(.DW(32), .BANKS(15), .DEPTH(3), .LOG_N(12), .RADIX_K(4),
                       .MUL_LAT(3), .CONST_N(13)) dut (
        .clk (clk), .rst (rst), .bus (tif.slave));

    tf_update_engine #(.DW(32), .BANKS(2), .DEPTH(3), .LOG_N(12), .RADIX_K(6),
                       .MUL_LAT(3), .CONST_N(13)) dut2 (
        .clk (clk), .rst (rst), .bus (tif2.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          depth;
        int          lane;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int m);
        return tif.tf_out[m*32-1 -: 32];
    endfunction

    // lane1 = l1, lane m (m>=2) = m
    function automatic logic [479:0] mk_base(input logic [31:0] l1);
        logic [479:0] v;
        for (int m = 1; m <= 15; m++) v[m*32-1 -: 32] = 32'(m);
        v[31:0] = l1;
        return v;
    endfunction

    task automatic req(input int d, input bit upd);
        tif.tf_req    = 1'b1;
        tif.tf_depth  = 2'(d);
        tif.tf_update = upd;
        tick();
        tif.tf_req    = 1'b0;
        tif.tf_update = 1'b0;
    endtask

    task automatic load_base(input int d, input logic [479:0] data);
        tif.base_wr_en    = 1'b1;
        tif.base_wr_depth = 2'(d);
        tif.base_wr_data  = data;
        tick();
        tif.base_wr_en    = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tif.tf_done) break;
        end
        chk(name, 64'(tif.tf_done), 64'd1);
    endtask

    logic [415:0] cdata;
    logic [479:0] bdata;

    initial begin
        tif.modulus = 32'd97;     tif.base_wr_en = 1'b0; tif.base_wr_depth = '0;
        tif.base_wr_data = '0;    tif.const_wr_en = 1'b0; tif.const_wr_data = '0;
        tif.tf_req = 1'b0;        tif.tf_depth = '0;      tif.tf_update = 1'b0;
        tif2.modulus = 32'd97;    tif2.base_wr_en = 1'b0; tif2.base_wr_depth = '0;
        tif2.base_wr_data = '0;   tif2.const_wr_en = 1'b0; tif2.const_wr_data = '0;
        tif2.tf_req = 1'b0;       tif2.tf_depth = '0;     tif2.tf_update = 1'b0;

        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_ready", 64'(tif.tf_ready), 64'd1);
        chk("rst_valid", 64'(tif.tf_valid), 64'd0);
        chk("rst_done",  64'(tif.tf_done),  64'd0);
        chk("rst_err",   64'(tif.tf_err),   64'd0);
        chk("rst_out",   64'(tif.tf_out == '0), 64'd1);

        // Reset asserted while the engine sits in WAIT
        cdata = '0;
        cdata[13*32-1 -: 32] = 32'd3;
        tif.const_wr_en = 1'b1; tif.const_wr_data = cdata;
        load_base(0, mk_base(32'd5));
        tif.const_wr_en = 1'b0;
        req(0, 1'b1);
        chk("abort_pre_valid", 64'(tif.tf_valid), 64'd1);
        tick();
        tick();
        chk("abort_busy", 64'(tif.tf_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("abort_ready", 64'(tif.tf_ready), 64'd1);
        chk("abort_out",   64'(tif.tf_out == '0), 64'd1);
        chk("abort_valid", 64'(tif.tf_valid | tif.tf_done | tif.tf_err), 64'd0);
        #2 rst = 1'b1;
        repeat (6) tick();
        chk("abort_no_done", 64'(tif.tf_done), 64'd0);
        req(0, 1'b0);
        chk("abort_base_cleared", 64'(lane(1)), 64'd0);
        tick();

        // Base and const loads in the same cycle
        cdata = '0;
        for (int i = 0; i < 13; i++) cdata[(i+1)*32-1 -: 32] = 32'd1;
        cdata[13*32-1 -: 32] = 32'd3;
        cdata[12*32-1 -: 32] = 32'd2;
        cdata[11*32-1 -: 32] = 32'd4;
        cdata[10*32-1 -: 32] = 32'd5;
        cdata[ 2*32-1 -: 32] = 32'd10;
        tif.const_wr_en = 1'b1; tif.const_wr_data = cdata;
        load_base(0, mk_base(32'd5));
        tif.const_wr_en = 1'b0;

        // Update of depth 0 with writeback timing
        req(0, 1'b1);
        chk("upd_valid", 64'(tif.tf_valid), 64'd1);
        chk("upd_lane1", 64'(lane(1)), 64'd5);
        chk("upd_busy",  64'(tif.tf_ready), 64'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("upd_done_early", 64'(tif.tf_done), 64'd0);
            chk("upd_valid_once", 64'(tif.tf_valid), 64'd0);
        end
        tick();
        chk("upd_done_pulse", 64'(tif.tf_done), 64'd1);
        chk("upd_ready_back", 64'(tif.tf_ready), 64'd1);
        tick();
        chk("upd_done_clear", 64'(tif.tf_done), 64'd0);

        // Read-only request: ready again after one READ cycle
        req(0, 1'b0);
        chk("rd_lane1_15", 64'(lane(1)), 64'd15);
        chk("rd_busy", 64'(tif.tf_ready), 64'd0);
        tick();
        chk("rd_ready_t2", 64'(tif.tf_ready), 64'd1);
        chk("rd_no_done", 64'(tif.tf_done), 64'd0);

        // Depth 2: lane8 uses const[1]=10, lane1 uses const[4]=1
        bdata = '0;
        bdata[31:0]    = 32'd7;
        bdata[255:224] = 32'd50;
        load_base(2, bdata);
        req(2, 1'b1);
        chk("d2_lane8_pre", 64'(lane(8)), 64'd50);
        wait_done("d2_done");

        // Out-of-range depth
        req(3, 1'b0);
        chk("err_pulse", 64'(tif.tf_err), 64'd1);
        chk("err_no_valid", 64'(tif.tf_valid), 64'd0);
        chk("err_ready", 64'(tif.tf_ready), 64'd1);
        chk("err_out_held", 64'(lane(1)), 64'd7);
        tick();
        chk("err_clear", 64'(tif.tf_err), 64'd0);

        // Requests and loads while busy are ignored
        req(0, 1'b1);
        chk("busy_first_lane1", 64'(lane(1)), 64'd15);
        for (int m = 1; m <= 15; m++) bdata[m*32-1 -: 32] = 32'd99;
        tif.base_wr_en = 1'b1; tif.base_wr_depth = 2'd0; tif.base_wr_data = bdata;
        tif.tf_req = 1'b1; tif.tf_depth = 2'd1;
        tick();
        chk("busy_no_valid_a", 64'(tif.tf_valid), 64'd0);
        tick();
        chk("busy_no_valid_b", 64'(tif.tf_valid), 64'd0);
        chk("busy_out_held", 64'(lane(1)), 64'd15);
        tif.base_wr_en = 1'b0; tif.tf_req = 1'b0;
        wait_done("busy_done");
        req(0, 1'b0);
        chk("busy_lane1_45", 64'(lane(1)), 64'd45);
        chk("busy_lane8_6",  64'(lane(8)), 64'd6);
        tick();

        // Same-cycle load and update request on depth 0
        load_base(0, mk_base(32'd5));
        bdata = '0;
        bdata[31:0] = 32'd7;
        tif.base_wr_en = 1'b1; tif.base_wr_depth = 2'd0; tif.base_wr_data = bdata;
        req(0, 1'b1);
        tif.base_wr_en = 1'b0;
        chk("same_old_lane1", 64'(lane(1)), 64'd5);
        wait_done("same_done");

        vecs[0]  = '{0, 1, 32'd15};
        vecs[1]  = '{0, 2, 32'd4};
        vecs[2]  = '{0, 3, 32'd6};
        vecs[3]  = '{0, 4, 32'd16};
        vecs[4]  = '{0, 7, 32'd28};
        vecs[5]  = '{0, 8, 32'd40};
        vecs[6]  = '{0, 15, 32'd75};
        vecs[7]  = '{2, 1, 32'd7};
        vecs[8]  = '{2, 8, 32'd15};
        vecs[9]  = '{2, 2, 32'd0};
        vecs[10] = '{1, 1, 32'd0};
        for (int i = 0; i < 11; i++) begin
            req(vecs[i].depth, 1'b0);
            chk($sformatf("tbl_d%0d_l%0d", vecs[i].depth, vecs[i].lane),
                64'(lane(vecs[i].lane)), 64'(vecs[i].exp));
            tick();
        end

        // RADIX_K=6 instance: depth 2 lane1 idx=0, lane2 idx=-1 (unchanged)
        cdata = '0;
        for (int i = 0; i < 13; i++) cdata[(i+1)*32-1 -: 32] = 32'd1;
        cdata[31:0] = 32'd3;
        tif2.const_wr_en = 1'b1; tif2.const_wr_data = cdata;
        tif2.base_wr_en = 1'b1; tif2.base_wr_depth = 2'd2;
        tif2.base_wr_data = {32'd9, 32'd5};
        tick();
        tif2.const_wr_en = 1'b0; tif2.base_wr_en = 1'b0;
        tif2.tf_req = 1'b1; tif2.tf_depth = 2'd2; tif2.tf_update = 1'b1;
        tick();
        tif2.tf_req = 1'b0; tif2.tf_update = 1'b0;
        repeat (6) tick();
        tif2.tf_req = 1'b1;
        tick();
        tif2.tf_req = 1'b0;
        chk("k6_valid", 64'(tif2.tf_valid), 64'd1);
        chk("k6_lane1_idx0", 64'(tif2.tf_out[31:0]), 64'd15);
        chk("k6_lane2_neg", 64'(tif2.tf_out[63:32]), 64'd9);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
